// File: rtl/rx_cmd_decoder_pkg.sv
// Shared RX/TX command definitions: command codes, ALU operand slots and the
// decoder FSM state encoding.
package rx_cmd_decoder_pkg;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU    = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT
  } state_e;

  function automatic logic is_alu_state(input state_e s);
    return (s == ALU_A) || (s == ALU_B) || (s == ALU_FUN) || (s == ALU_WAIT);
  endfunction

endpackage

// File: rtl/rx_cmd_decoder_if.sv
// Byte-stream, ALU and register-file signals seen by the RX command decoder.
// The slave view belongs to the decoder; the master view to its environment.
interface rx_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  alu_out_valid;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  alu_en;
  logic [3:0]            alu_fun;
  logic                  clk_gate_en;
  logic                  cmd_err;

  modport slave (
    input  rx_data, rx_valid, alu_out_valid,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
           alu_en, alu_fun, clk_gate_en, cmd_err
  );

  modport master (
    output rx_data, rx_valid, alu_out_valid,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
           alu_en, alu_fun, clk_gate_en, cmd_err
  );

endinterface

// File: rtl/rx_cmd_decoder.sv
// Decodes the RX byte stream into register-file and ALU strobes. Every output
// is registered, so each strobe lands one clock after the byte that caused it.
module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  rx_cmd_decoder_if.slave  bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  clk_gate_q, clk_gate_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  cmd_known;

  assign cmd_known = (bus.rx_data == DATA_WIDTH'(CMD_WR))     ||
                     (bus.rx_data == DATA_WIDTH'(CMD_RD))     ||
                     (bus.rx_data == DATA_WIDTH'(CMD_ALU_OP)) ||
                     (bus.rx_data == DATA_WIDTH'(CMD_ALU));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.rx_valid) begin
        if      (bus.rx_data == DATA_WIDTH'(CMD_WR))     state_d = WR_ADDR;
        else if (bus.rx_data == DATA_WIDTH'(CMD_RD))     state_d = RD_ADDR;
        else if (bus.rx_data == DATA_WIDTH'(CMD_ALU_OP)) state_d = ALU_A;
        else if (bus.rx_data == DATA_WIDTH'(CMD_ALU))    state_d = ALU_FUN;
      end
      WR_ADDR:  if (bus.rx_valid) state_d = WR_DATA;
      WR_DATA:  if (bus.rx_valid) state_d = IDLE;
      RD_ADDR:  if (bus.rx_valid) state_d = IDLE;
      ALU_A:    if (bus.rx_valid) state_d = ALU_B;
      ALU_B:    if (bus.rx_valid) state_d = ALU_FUN;
      ALU_FUN:  if (bus.rx_valid) state_d = ALU_WAIT;
      ALU_WAIT: if (bus.alu_out_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Address/data/function registers hold between strobes; strobes default low.
  always_comb begin
    addr_d       = addr_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun_q;
    cmd_err_d    = 1'b0;
    // Overlapping the current and next state keeps the gate open from the
    // cycle after the ALU command through the cycle after alu_out_valid.
    clk_gate_d   = is_alu_state(state_q) || is_alu_state(state_d);
    if (bus.rx_valid) begin
      case (state_q)
        IDLE:    cmd_err_d = !cmd_known;
        WR_ADDR: addr_d = bus.rx_data[ADDR_WIDTH-1:0];
        WR_DATA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = bus.rx_data;
        end
        RD_ADDR: begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
        end
        ALU_A, ALU_B: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = (state_q == ALU_A) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_d = bus.rx_data;
        end
        ALU_FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = bus.rx_data[3:0];
        end
        ALU_WAIT: cmd_err_d = 1'b1;
        default:  cmd_err_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q       <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      clk_gate_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      clk_gate_q   <= clk_gate_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: inputs change on the falling edge and
// outputs are checked on the following falling edge (one clock later).
module tb_rx_cmd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rx_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply one cycle of input, then return on the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic aov);
    bus.rx_valid      = v;
    bus.rx_data       = d;
    bus.alu_out_valid = aov;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_en"},   32'(bus.rf_wr_en),    32'h0);
    check_eq({tag, "_rd_en"},   32'(bus.rf_rd_en),    32'h0);
    check_eq({tag, "_addr"},    32'(bus.rf_addr),     32'h0);
    check_eq({tag, "_wr_data"}, 32'(bus.rf_wr_data),  32'h0);
    check_eq({tag, "_alu_en"},  32'(bus.alu_en),      32'h0);
    check_eq({tag, "_alu_fun"}, 32'(bus.alu_fun),     32'h0);
    check_eq({tag, "_gate"},    32'(bus.clk_gate_en), 32'h0);
    check_eq({tag, "_err"},     32'(bus.cmd_err),     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.alu_out_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Write: AA,05,3C
    cycle(1'b1, 8'hAA, 1'b0);
    check_eq("wr_cmd_no_strobe", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b1, 8'h05, 1'b0);
    check_eq("wr_addr_no_strobe", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b1, 8'h3C, 1'b0);
    check_eq("wr_en", 32'(bus.rf_wr_en), 32'h1);
    check_eq("wr_addr", 32'(bus.rf_addr), 32'h5);
    check_eq("wr_data", 32'(bus.rf_wr_data), 32'h3C);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("wr_en_one_cycle", 32'(bus.rf_wr_en), 32'h0);
    check_eq("wr_addr_hold", 32'(bus.rf_addr), 32'h5);
    check_eq("wr_data_hold", 32'(bus.rf_wr_data), 32'h3C);

    // Read: BB,0A
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0);
    check_eq("rd_en", 32'(bus.rf_rd_en), 32'h1);
    check_eq("rd_addr", 32'(bus.rf_addr), 32'hA);
    check_eq("rd_no_wr", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("rd_en_one_cycle", 32'(bus.rf_rd_en), 32'h0);

    // ALU with operands: CC,07,03,01
    cycle(1'b1, 8'hCC, 1'b0);
    check_eq("aluop_gate_on", 32'(bus.clk_gate_en), 32'h1);
    check_eq("aluop_cmd_no_wr", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b1, 8'h07, 1'b0);
    check_eq("opa_wr_en", 32'(bus.rf_wr_en), 32'h1);
    check_eq("opa_addr", 32'(bus.rf_addr), 32'h0);
    check_eq("opa_data", 32'(bus.rf_wr_data), 32'h07);
    cycle(1'b1, 8'h03, 1'b0);
    check_eq("opb_wr_en", 32'(bus.rf_wr_en), 32'h1);
    check_eq("opb_addr", 32'(bus.rf_addr), 32'h1);
    check_eq("opb_data", 32'(bus.rf_wr_data), 32'h03);
    cycle(1'b1, 8'h01, 1'b0);
    check_eq("alu_en", 32'(bus.alu_en), 32'h1);
    check_eq("alu_fun", 32'(bus.alu_fun), 32'h1);
    check_eq("fun_no_wr", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("alu_en_one_cycle", 32'(bus.alu_en), 32'h0);
    check_eq("alu_fun_hold", 32'(bus.alu_fun), 32'h1);
    check_eq("wait_gate_on", 32'(bus.clk_gate_en), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("gate_after_done", 32'(bus.clk_gate_en), 32'h1);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("gate_off", 32'(bus.clk_gate_en), 32'h0);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("idle_done_ignored_gate", 32'(bus.clk_gate_en), 32'h0);
    check_eq("idle_done_ignored_err", 32'(bus.cmd_err), 32'h0);

    // Unknown command in IDLE, then confirm the decoder is still in IDLE.
    cycle(1'b1, 8'h55, 1'b0);
    check_eq("unknown_err", 32'(bus.cmd_err), 32'h1);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("unknown_err_one_cycle", 32'(bus.cmd_err), 32'h0);
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    check_eq("post_unknown_rd_en", 32'(bus.rf_rd_en), 32'h1);
    check_eq("post_unknown_rd_addr", 32'(bus.rf_addr), 32'h3);

    // Byte dropped while busy: DD,02 then AA during ALU_WAIT.
    cycle(1'b1, 8'hDD, 1'b0);
    check_eq("alu_gate_on", 32'(bus.clk_gate_en), 32'h1);
    cycle(1'b1, 8'h02, 1'b0);
    check_eq("alu2_en", 32'(bus.alu_en), 32'h1);
    check_eq("alu2_fun", 32'(bus.alu_fun), 32'h2);
    cycle(1'b1, 8'hAA, 1'b0);
    check_eq("busy_err", 32'(bus.cmd_err), 32'h1);
    check_eq("busy_no_wr", 32'(bus.rf_wr_en), 32'h0);
    check_eq("busy_no_rd", 32'(bus.rf_rd_en), 32'h0);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("busy_err_one_cycle", 32'(bus.cmd_err), 32'h0);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("alu2_gate_off", 32'(bus.clk_gate_en), 32'h0);

    // rx_valid coincides with alu_out_valid: error, back to IDLE, byte dropped.
    cycle(1'b1, 8'hDD, 1'b0);
    cycle(1'b1, 8'h04, 1'b0);
    cycle(1'b1, 8'hBB, 1'b1);
    check_eq("coincide_err", 32'(bus.cmd_err), 32'h1);
    check_eq("coincide_no_rd", 32'(bus.rf_rd_en), 32'h0);
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'h06, 1'b0);
    check_eq("coincide_rd_en", 32'(bus.rf_rd_en), 32'h1);
    check_eq("coincide_rd_addr", 32'(bus.rf_addr), 32'h6);
    cycle(1'b0, 8'h00, 1'b0);

    // Asynchronous reset between AA and its address byte.
    cycle(1'b1, 8'hAA, 1'b0);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cycle(1'b1, 8'hBB, 1'b0);
    check_eq("post_rst_no_wr", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b1, 8'h02, 1'b0);
    check_eq("post_rst_rd_en", 32'(bus.rf_rd_en), 32'h1);
    check_eq("post_rst_rd_addr", 32'(bus.rf_addr), 32'h2);
    check_eq("post_rst_no_wr2", 32'(bus.rf_wr_en), 32'h0);

    // Back-to-back: AA,01,FF,BB,01 on consecutive cycles.
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    check_eq("b2b_wr_en", 32'(bus.rf_wr_en), 32'h1);
    check_eq("b2b_wr_addr", 32'(bus.rf_addr), 32'h1);
    check_eq("b2b_wr_data", 32'(bus.rf_wr_data), 32'hFF);
    cycle(1'b1, 8'hBB, 1'b0);
    check_eq("b2b_mid_err", 32'(bus.cmd_err), 32'h0);
    check_eq("b2b_mid_wr", 32'(bus.rf_wr_en), 32'h0);
    cycle(1'b1, 8'h01, 1'b0);
    check_eq("b2b_rd_en", 32'(bus.rf_rd_en), 32'h1);
    check_eq("b2b_rd_addr", 32'(bus.rf_addr), 32'h1);
    check_eq("b2b_err", 32'(bus.cmd_err), 32'h0);
    cycle(1'b0, 8'h00, 1'b0);
    check_eq("b2b_rd_one_cycle", 32'(bus.rf_rd_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of command/data bytes and RF write data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: width of register-file address.
REQ-003 SHALL have port CLK, input, 1: single clock; all logic is in this domain.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, DATA_WIDTH: synchronized byte, valid only when rx_valid=1.
REQ-006 SHALL have port rx_valid, input, 1: single-cycle byte strobe from the synchronizer; cannot be back-pressured.
REQ-007 SHALL have port alu_out_valid, input, 1: ALU result-done strobe.
REQ-008 SHALL have port rf_wr_en, output, 1: one-cycle register-file write strobe.
REQ-009 SHALL have port rf_rd_en, output, 1: one-cycle register-file read strobe.
REQ-010 SHALL have port rf_addr, output, ADDR_WIDTH: RF address, valid with rf_wr_en/rf_rd_en.
REQ-011 SHALL have port rf_wr_data, output, DATA_WIDTH: RF write data, valid with rf_wr_en.
REQ-012 SHALL have port alu_en, output, 1: one-cycle ALU start strobe.
REQ-013 SHALL have port alu_fun, output, 4: ALU function code, valid with alu_en and held until the next alu_en.
REQ-014 SHALL have port clk_gate_en, output, 1: ALU clock-gate enable.
REQ-015 SHALL have port cmd_err, output, 1: one-cycle strobe for an unknown command byte or a byte dropped while busy.

Function
REQ-016 SHALL decode these commands:
- 0xAA = write: addr byte, then data byte.
- 0xBB = read: addr byte.
- 0xCC = ALU with operands: A byte, B byte, then fun byte.
- 0xDD = ALU without operands: fun byte.
REQ-017 SHALL implement an FSM with states IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, ALU_WAIT; it advances only on cycles with rx_valid=1, except ALU_WAIT.
REQ-018 SHALL handle IDLE + rx_valid as follows:
- 0xAA -> WR_ADDR.
- 0xBB -> RD_ADDR.
- 0xCC -> ALU_A.
- 0xDD -> ALU_FUN.
- Any other value -> cmd_err=1 next cycle, stay IDLE.
REQ-019 SHALL, in WR_ADDR, latch rx_data[ADDR_WIDTH-1:0] as the address -> WR_DATA; in WR_DATA, issue rf_wr_en with the latched address and rx_data -> IDLE.
REQ-020 SHALL, in RD_ADDR, issue rf_rd_en with rf_addr=rx_data[ADDR_WIDTH-1:0] -> IDLE.
REQ-021 SHALL, in ALU_A, write rx_data to RF address 0 -> ALU_B; in ALU_B, write rx_data to RF address 1 -> ALU_FUN.
REQ-022 SHALL, in ALU_FUN, issue alu_en with alu_fun=rx_data[3:0] -> ALU_WAIT.
REQ-023 SHALL, in ALU_WAIT, return to IDLE on alu_out_valid=1; rx_valid in ALU_WAIT drops the byte and pulses cmd_err.
REQ-024 SHALL register all strobes: each appears exactly 1 CLK after the rx_valid cycle that caused it, high for exactly one cycle.
REQ-025 SHALL assert clk_gate_en from the cycle after a 0xCC/0xDD byte is accepted until the cycle after alu_out_valid, inclusive of every ALU_* state.
REQ-026 SHALL ignore alu_out_valid outside ALU_WAIT.
REQ-027 SHALL hold rf_addr and rf_wr_data at their last values between strobes.
REQ-028 SHALL, when rx_valid and alu_out_valid coincide in ALU_WAIT, return to IDLE and pulse cmd_err; the byte is not decoded.
REQ-029 SHALL accept back-to-back rx_valid on consecutive cycles in all non-wait states with no loss.

Reset
REQ-030 SHALL, on RST=1 (asynchronous, any time including mid-frame), force state to IDLE and drive every output to 0 (including rf_addr, rf_wr_data, alu_fun) and clear the latched address.
REQ-031 SHALL resume decoding a fresh frame on the first rx_valid after RST deasserts; partial-frame state is discarded.

Structure
REQ-032 SHALL take command codes 0xAA/0xBB/0xCC/0xDD, ALU operand addresses 0/1 and the FSM state enum from a shared package used by the future TX-side controller.
REQ-033 SHALL be a single module with no sub-module; the FSM and output registers are flat.

Verification
REQ-034 SHALL have a bench cover write: bytes AA,05,3C -> one rf_wr_en, rf_addr=5, rf_wr_data=0x3C, 1 cycle after 3rd byte.
REQ-035 SHALL have a bench cover read: bytes BB,0A -> one rf_rd_en with rf_addr=0xA; no rf_wr_en.
REQ-036 SHALL have a bench cover ALU with operands: bytes CC,07,03,01 -> rf writes (0,07) then (1,03), alu_en with alu_fun=1, clk_gate_en high until 1 cycle after alu_out_valid.
REQ-037 SHALL have a bench cover unknown command/busy: byte 55 in IDLE -> cmd_err pulse, state IDLE; byte during ALU_WAIT after DD,02 -> cmd_err, no RF strobe.
REQ-038 SHALL have a bench cover reset: RST pulse between AA and its addr byte -> all outputs 0; subsequent BB,02 -> rf_rd_en rf_addr=2.
REQ-039 SHALL have a bench cover back-to-back: AA,01,FF,BB,01 on consecutive cycles -> rf_wr_en then rf_rd_en, both addr 1, no cmd_err.
